// File: rtl/nv_ram_rws_16x64_fifo_pkg.sv
// Shared constants and types for the 16x64 rws-RAM FIFO controller and its output skid.
package nv_ram_rws_fifo_pkg;

    localparam int WIDTH    = 64;
    localparam int AW       = 4;
    localparam int DEPTH    = 1 << AW;
    localparam int OB_DEPTH = 2;
    localparam int CNT_W    = 5;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   used_t;    // holds 0..DEPTH inclusive
    typedef logic [1:0]    ob_cnt_t;  // holds 0..OB_DEPTH inclusive

endpackage

// File: rtl/nv_ram_rws_16x64_fifo_if.sv
// Valid/ready pipe bundle used for both the write and the read side of the FIFO.
interface nv_ram_rws_16x64_fifo_if
    import nv_ram_rws_fifo_pkg::*;
();
    logic             pvld;
    logic             prdy;
    logic [WIDTH-1:0] pd;

    modport master (output pvld, output pd, input prdy);
    modport slave  (input pvld, input pd, output prdy);
endinterface

// File: rtl/nv_ram_rws_16x64_fifo_skid.sv
// Two-entry output stage: head register drives rd_pd and keeps its last value when empty.
module nv_ram_rws_fifo_skid
    import nv_ram_rws_fifo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output ob_cnt_t          cnt
);

    logic [WIDTH-1:0] tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data registers are reset too, so rd_pd reads 0 rather than X after reset.
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments let every branch below read the pre-edge cnt/tail.
            cnt <= cnt + ob_cnt_t'(push) - ob_cnt_t'(pop);
            if (pop && cnt == 2'd2) begin
                head <= tail;
                if (push) tail <= din;
            end else if (push && (cnt == 2'd0 || pop)) begin
                head <= din;
            end else if (push) begin
                tail <= din;
            end else if (load && cnt == 2'd0) begin
                // a bypassed word is remembered so rd_pd still holds the last value shown
                head <= din;
            end
        end
    end

endmodule

// File: rtl/nv_ram_rws_16x64_fifo.sv
// FIFO controller mastering a 16x64 rws RAM with a 2-entry output skid.
// Optional macro NV_RAM_RWS_FIFO_RD_BYPASS_EN presents RAM data directly when the skid is empty.
module nv_ram_rws_16x64_fifo
    import nv_ram_rws_fifo_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    nv_ram_rws_16x64_fifo_if.slave   wr,
    nv_ram_rws_16x64_fifo_if.master  rd,
    output ptr_t                     ram_wa,
    output logic                     ram_we,
    output logic [WIDTH-1:0]         ram_di,
    output ptr_t                     ram_ra,
    output logic                     ram_re,
    input  logic [WIDTH-1:0]         ram_dout,
    input  logic [31:0]              pwrbus_ram_pd,
    output logic [31:0]              ram_pwrbus_pd,
    output logic [CNT_W-1:0]         count
);

    ptr_t             wr_ptr, rd_ptr;
    used_t            ram_used, ram_avail, used_nxt, avail_nxt;
    logic             inflight;
    ob_cnt_t          ob_cnt, ob_cnt_nxt;
    logic [WIDTH-1:0] ob_head;
    logic             byp, ob_pop, skid_pop, byp_pop, ob_push;

    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no latch is inferred.
`ifdef NV_RAM_RWS_FIFO_RD_BYPASS_EN
        byp = inflight && (ob_cnt == 2'd0);
`else
        byp = 1'b0;
`endif
        wr.prdy  = !rst && (ram_used < used_t'(DEPTH));
        ram_we   = wr.pvld && wr.prdy;
        ram_wa   = wr_ptr;
        ram_di   = wr.pd;
        ram_ra   = rd_ptr;

        rd.pvld  = (ob_cnt != 2'd0) || byp;
        rd.pd    = byp ? ram_dout : ob_head;
        ob_pop   = rd.pvld && rd.prdy;
        skid_pop = ob_pop && !byp;
        byp_pop  = ob_pop && byp;
        ob_push  = inflight && !byp_pop;

        // only issue when the returning word is guaranteed a skid slot
        ram_re   = !rst && (ram_avail != '0) &&
                   (({1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, ob_pop}) < 3'(OB_DEPTH));

        used_nxt   = ram_used + used_t'(ram_we) - used_t'(inflight);
        avail_nxt  = ram_avail + used_t'(ram_we) - used_t'(ram_re);
        ob_cnt_nxt = ob_cnt + ob_cnt_t'(ob_push) - ob_cnt_t'(skid_pop);
    end

    assign ram_pwrbus_pd = pwrbus_ram_pd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_used  <= '0;
            ram_avail <= '0;
            inflight  <= 1'b0;
            count     <= '0;
        end else begin
            if (ram_we) wr_ptr <= wr_ptr + ptr_t'(1);
            if (ram_re) rd_ptr <= rd_ptr + ptr_t'(1);
            // a RAM slot is released only once its read data has been captured
            ram_used  <= used_nxt;
            ram_avail <= avail_nxt;
            inflight  <= ram_re;
            count     <= CNT_W'(used_nxt) + CNT_W'(ob_cnt_nxt);
        end
    end

    nv_ram_rws_fifo_skid u_skid (
        .clk  (clk),
        .rst  (rst),
        .push (ob_push),
        .pop  (skid_pop),
        .load (byp_pop),
        .din  (ram_dout),
        .head (ob_head),
        .cnt  (ob_cnt)
    );

endmodule

// File: tb/tb_nv_ram_rws_16x64_fifo.sv
// Self-checking bench: vector table, corner sequences and a random run against a queue scoreboard.
module tb_nv_ram_rws_16x64_fifo;
    import nv_ram_rws_fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    ptr_t        ram_wa, ram_ra;
    logic        ram_we, ram_re;
    logic [63:0] ram_di, ram_dout;
    logic [31:0] pwr_in, pwr_out;
    logic [4:0]  count;

    nv_ram_rws_16x64_fifo_if wr();
    nv_ram_rws_16x64_fifo_if rd();

    nv_ram_rws_16x64_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .wr            (wr),
        .rd            (rd),
        .ram_wa        (ram_wa),
        .ram_we        (ram_we),
        .ram_di        (ram_di),
        .ram_ra        (ram_ra),
        .ram_re        (ram_re),
        .ram_dout      (ram_dout),
        .pwrbus_ram_pd (pwr_in),
        .ram_pwrbus_pd (pwr_out),
        .count         (count)
    );

    always #5 clk = ~clk;

    // behavioural rws RAM: write on edge, registered read address, data one cycle later
    logic [63:0] mem [16] = '{default: '0};
    ptr_t        ra_q = '0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
    end
    assign ram_dout = mem[ra_q];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // reference model: ordered queue of accepted words, occupancy, slot ownership
    logic [63:0] sb[$];
    int          occ = 0, n_acc = 0, n_iss = 0;
    bit          busy [16];
    bit          pend = 1'b0;
    ptr_t        pend_a = '0;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            occ = 0; n_acc = 0; n_iss = 0; pend = 1'b0;
            foreach (busy[i]) busy[i] = 1'b0;
        end else begin
            check("count", count, occ);
            check("ram_we", ram_we, wr.pvld & wr.prdy);
            if (occ == 0)  check("idle_pvld", rd.pvld, 0);
            if (occ < 16)  check("wr_prdy_room", wr.prdy, 1);
            if (occ >= 18) check("wr_prdy_full", wr.prdy, 0);
            if (ram_we) begin
                check("ram_wa", ram_wa, n_acc % 16);
                check("slot_free", busy[ram_wa], 0);
            end
            if (pend) busy[pend_a] = 1'b0;
            pend = 1'b0;
            if (ram_re) begin
                check("ram_ra", ram_ra, n_iss % 16);
                check("re_has_data", busy[ram_ra], 1);
                check("re_after_wr", n_iss < n_acc, 1);
                pend = 1'b1; pend_a = ram_ra; n_iss++;
            end
            if (rd.pvld && rd.prdy) begin
                check("pop_avail", sb.size() > 0, 1);
                if (sb.size() > 0) check("rd_pd", rd.pd, sb.pop_front());
                occ--;
            end
            if (ram_we) begin
                busy[ram_wa] = 1'b1;
                sb.push_back(wr.pd);
                n_acc++;
                occ++;
            end
        end
    end

    typedef struct {
        logic        wv;
        logic [63:0] wd;
        logic        rr;
        logic        we;
        logic [3:0]  wa;
        logic        re;
        logic [3:0]  ra;
        logic        pvld;
        logic [63:0] pd;
        logic [4:0]  cnt;
    } vec_t;

    localparam logic [63:0] D = 64'hDEAD_BEEF_0000_0001;
    vec_t vecs [5];

    task automatic run_table(input string tag);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            wr.pvld = vecs[i].wv; wr.pd = vecs[i].wd; rd.prdy = vecs[i].rr;
            @(negedge clk);
            check($sformatf("%s%0d_we", tag, i),   ram_we,  vecs[i].we);
            if (vecs[i].we) check($sformatf("%s%0d_wa", tag, i), ram_wa, vecs[i].wa);
            check($sformatf("%s%0d_re", tag, i),   ram_re,  vecs[i].re);
            check($sformatf("%s%0d_ra", tag, i),   ram_ra,  vecs[i].ra);
            check($sformatf("%s%0d_pvld", tag, i), rd.pvld, vecs[i].pvld);
            check($sformatf("%s%0d_pd", tag, i),   rd.pd,   vecs[i].pd);
            check($sformatf("%s%0d_cnt", tag, i),  count,   vecs[i].cnt);
        end
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            wr.pvld = 1'b0; rd.prdy = 1'b1;
            @(negedge clk);
            if (count == 5'd0 && !rd.pvld) break;
        end
        check({name, "_count"}, count, 0);
        check({name, "_left"}, sb.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int val, pops;

        vecs[0] = '{1'b1, D,     1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 64'd0, 5'd0};
        vecs[1] = '{1'b0, 64'd0, 1'b1, 1'b0, 4'd1, 1'b1, 4'd0, 1'b0, 64'd0, 5'd1};
`ifdef NV_RAM_RWS_FIFO_RD_BYPASS_EN
        vecs[2] = '{1'b0, 64'd0, 1'b1, 1'b0, 4'd1, 1'b0, 4'd1, 1'b1, D,     5'd1};
        vecs[3] = '{1'b0, 64'd0, 1'b1, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0, D,     5'd0};
`else
        vecs[2] = '{1'b0, 64'd0, 1'b1, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0, 64'd0, 5'd1};
        vecs[3] = '{1'b0, 64'd0, 1'b1, 1'b0, 4'd1, 1'b0, 4'd1, 1'b1, D,     5'd1};
`endif
        vecs[4] = '{1'b0, 64'd0, 1'b1, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0, D,     5'd0};

        // reset state, with a write being offered to prove it is blocked
        rst = 1'b1; wr.pvld = 1'b1; wr.pd = '1; rd.prdy = 1'b1; pwr_in = 32'hA5C3_0F01;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pvld", rd.pvld, 0);
        check("rst_pd", rd.pd, 0);
        check("rst_count", count, 0);
        check("rst_wr_prdy", wr.prdy, 0);
        check("rst_we", ram_we, 0);
        check("rst_re", ram_re, 0);
        check("pwrbus_a", pwr_out, 32'hA5C3_0F01);
        pwr_in = 32'h1234_5678;
        #1;
        check("pwrbus_b", pwr_out, 32'h1234_5678);
        rst = 1'b0; wr.pvld = 1'b0; rd.prdy = 1'b0;

        run_table("single");

        // fill: offer 0..19 with no reads, only 18 fit
        val = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            wr.pvld = (val < 20); wr.pd = 64'(val); rd.prdy = 1'b0;
            @(negedge clk);
            if (wr.pvld && wr.prdy) val++;
        end
        check("fill_accepted", val, 18);
        check("fill_count", count, 18);
        check("fill_wr_prdy", wr.prdy, 0);
        check("fill_re", ram_re, 0);
        check("fill_head", rd.pd, 0);

        // full with a single pop: slot frees only after capture
        @(posedge clk); #1;
        rd.prdy = 1'b1; wr.pvld = 1'b1; wr.pd = 64'd18;
        @(negedge clk);
        check("fp0_wr_prdy", wr.prdy, 0);
        check("fp0_re", ram_re, 1);
        check("fp0_count", count, 18);
        @(posedge clk); #1;
        rd.prdy = 1'b0;
        @(negedge clk);
        check("fp1_count", count, 17);
        check("fp1_wr_prdy", wr.prdy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("fp2_count", count, 17);
        check("fp2_wr_prdy", wr.prdy, 1);
        @(posedge clk); #1;
        wr.pvld = 1'b0;
        @(negedge clk);
        check("fp3_count", count, 18);
        check("fp3_wr_prdy", wr.prdy, 0);
        drain("fill_drain");

        // streaming at full rate on both sides, pointers wrap
        pops = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            wr.pvld = 1'b1; wr.pd = {$urandom, $urandom}; rd.prdy = 1'b1;
            @(negedge clk);
            if (c >= 5 && rd.pvld && rd.prdy) pops++;
        end
        check("stream_rate", pops, 35);
        drain("stream_drain");

        // random traffic, heavy writes first then heavy reads
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            wr.pvld = (c < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            wr.pd   = {$urandom, $urandom};
            rd.prdy = $urandom_range(0, 1) != 0;
            @(negedge clk);
        end
        drain("rand_drain");

        // reset with count=7 and a read in flight
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            wr.pvld = 1'b1; wr.pd = {$urandom, $urandom}; rd.prdy = 1'b0;
            @(negedge clk);
        end
        @(posedge clk); #1;
        wr.pvld = 1'b0; rd.prdy = 1'b1;
        @(negedge clk);
        check("mr_count8", count, 8);
        check("mr_re", ram_re, 1);
        @(posedge clk); #1;
        rd.prdy = 1'b0;
        check("mr_count7", count, 7);
        rst = 1'b1;
        #1;
        check("mr_pvld", rd.pvld, 0);
        check("mr_count", count, 0);
        check("mr_wr_prdy", wr.prdy, 0);
        check("mr_re_off", ram_re, 0);
        check("mr_pd", rd.pd, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_table("post_rst");
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
